semaforo_fsm: RTL and testbench
===============================

Name: semaforo_fsm

Overview:
- Moore-type controller for a two-street intersection: street A, with traffic sensor TA and lights LA; street B, with traffic sensor TB and lights LB.
- Green stays on a street while its sensor reports traffic. When traffic clears, that street's light goes yellow, then the right of way passes to the other street.
- Sits between the debounced sensor inputs and the lamp drivers in the intersection top level.

Parameters:
- YELLOW_CYCLES, 1: clock cycles spent in each yellow state; legal range 1..255.
- CNT_W, 8: width of the internal yellow-dwell counter; must satisfy 2^CNT_W > YELLOW_CYCLES.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- TA  input  1  1 = traffic present on street A.
- TB  input  1  1 = traffic present on street B.
- LA  output  2  street A light: 2'b00 green, 2'b01 yellow, 2'b10 red; 2'b11 never driven.
- LB  output  2  street B light; same encoding as LA.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- States and outputs:
  - S0: LA=green, LB=red.
  - S1: LA=yellow, LB=red.
  - S2: LA=red, LB=green.
  - S3: LA=red, LB=yellow.
- Reset: on any rising edge with reset=1 → S0, counter=0, so LA=00 and LB=10.
  - Reset overrides all transitions, including mid-yellow.
  - TA/TB are ignored while reset=1; they may be X/undefined during reset.
- Outputs are a pure decode of the state register (Moore). They change only after a rising edge and never combinationally from TA/TB.
- Transitions are evaluated at each rising edge with reset=0:
  - S0: TA=1 → stay S0; TA=0 → S1, counter cleared. TB is ignored in S0.
  - S1: counter increments each cycle. When counter = YELLOW_CYCLES-1 → S2; otherwise stay. TA/TB ignored.
  - S2: TB=1 → stay S2; TB=0 → S3, counter cleared. TA is ignored in S2.
  - S3: same counter rule as S1; at terminal count → S0.
- Timing with YELLOW_CYCLES=1: each yellow lasts exactly one cycle. Green-to-green handover takes 2 edges after the sensor falls.
- TA=1 and TB=1 together: the current green street keeps green indefinitely. There is no fairness timer.
- TA=0 and TB=0 together: continuous cycle S0→S1→S2→S3→S0, period 2+2·YELLOW_CYCLES cycles (4 with the default).
- Safety invariant: LA and LB are never both non-red; at least one of them is 2'b10 in every cycle.
- Illegal or unreachable state encodings → S0 on the next edge.
- The counter saturates; it never wraps inside a yellow state.

Test Plan:
- Hold reset=1 for 3 edges with TA/TB = X → LA=00, LB=10 throughout. Release reset with TA=1 → stays in S0.
- From S0, set TA=0, TB=1 → next edge LA=01/LB=10; following edge LA=10/LB=00. Holds LB=00 for 4+ cycles while TB=1.
- From S2, set TA=1, TB=0 → next edge LA=10/LB=01; following edge LA=00/LB=10. Holds while TA=1.
- TA=1, TB=1 for 5 cycles starting in S0 → LA=00/LB=10 constant. Starting in S2 → LA=10/LB=00 constant.
- TA=0, TB=0 for 5+ cycles → sequence (00,10),(01,10),(10,00),(10,01),(00,10)…, period 4. The one-red invariant holds every cycle.
- Assert reset while in S1 or S3 → the next edge gives LA=00/LB=10. Also rerun with YELLOW_CYCLES=3 → each yellow lasts exactly 3 cycles.

Source files
------------

// File: rtl/semaforo_fsm.sv
// Moore traffic-light controller for a two-street intersection.
// Green holds while the street's sensor is active, then yellow for YELLOW_CYCLES, then handover.
module semaforo_fsm #(
  parameter int unsigned YELLOW_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       TA,
  input  logic       TB,
  output logic [1:0] LA,
  output logic [1:0] LB
);

  typedef enum logic [1:0] {
    S0 = 2'd0,  // A green, B red
    S1 = 2'd1,  // A yellow, B red
    S2 = 2'd2,  // A red, B green
    S3 = 2'd3   // A red, B yellow
  } state_e;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(YELLOW_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       la_q, la_d;
  logic [1:0]       lb_q, lb_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S0: begin
        if (!TA) begin
          state_d = S1;
          cnt_d   = '0;
        end
      end
      S1: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S2;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S2: begin
        if (!TB) begin
          state_d = S3;
          cnt_d   = '0;
        end
      end
      S3: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S0;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S0;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamp registers are loaded with the decode of the next state, so they always
  // match the state register without a combinational path from TA/TB.
  always_comb begin
    la_d = GREEN;
    lb_d = RED;
    case (state_d)
      S0:      begin la_d = GREEN;  lb_d = RED;    end
      S1:      begin la_d = YELLOW; lb_d = RED;    end
      S2:      begin la_d = RED;    lb_d = GREEN;  end
      S3:      begin la_d = RED;    lb_d = YELLOW; end
      default: begin la_d = GREEN;  lb_d = RED;    end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S0;
      cnt_q   <= '0;
      la_q    <= GREEN;
      lb_q    <= RED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
    end
  end

  assign LA = la_q;
  assign LB = lb_q;

endmodule

// File: tb/tb_semaforo_fsm.sv
// Bench for semaforo_fsm: default and 3-cycle-yellow instances against a street/yellow-countdown model.
module tb_semaforo_fsm;

  logic       clock;
  logic       reset;
  logic       TA;
  logic       TB;
  logic [1:0] la1, lb1, la3, lb3;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Model per instance: which street owns the right of way, and yellow cycles left (0 = green)
  int m_street [2];
  int m_yel    [2];
  int ycyc     [2];

  semaforo_fsm #(.YELLOW_CYCLES(1), .CNT_W(8)) dut1 (
    .clock(clock), .reset(reset), .TA(TA), .TB(TB), .LA(la1), .LB(lb1)
  );

  semaforo_fsm #(.YELLOW_CYCLES(3), .CNT_W(8)) dut3 (
    .clock(clock), .reset(reset), .TA(TA), .TB(TB), .LA(la3), .LB(lb3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_light(input int i, input int street);
    if (m_street[i] != street) return 2'b10;
    return (m_yel[i] != 0) ? 2'b01 : 2'b00;
  endfunction

  task automatic tick(input logic rst, input logic ta, input logic tb);
    logic sensor;
    reset = rst;
    TA    = ta;
    TB    = tb;
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_street[i] = 0;
        m_yel[i]    = 0;
      end else if (m_yel[i] == 0) begin
        sensor = (m_street[i] == 0) ? ta : tb;
        if (sensor == 1'b0) m_yel[i] = ycyc[i];
      end else begin
        m_yel[i] = m_yel[i] - 1;
        if (m_yel[i] == 0) m_street[i] = 1 - m_street[i];
      end
    end
    #1;
    check("LA_y1", la1, exp_light(0, 0));
    check("LB_y1", lb1, exp_light(0, 1));
    check("LA_y3", la3, exp_light(1, 0));
    check("LB_y3", lb3, exp_light(1, 1));
    check("onered_y1", {1'b0, (la1 == 2'b10) || (lb1 == 2'b10)}, 2'b01);
    check("onered_y3", {1'b0, (la3 == 2'b10) || (lb3 == 2'b10)}, 2'b01);
  endtask

  initial begin
    ycyc[0] = 1;
    ycyc[1] = 3;
    m_street[0] = 0; m_street[1] = 0;
    m_yel[0] = 0;    m_yel[1] = 0;
    reset = 1'b1;
    TA = 1'bx;
    TB = 1'bx;

    // Reset with undefined sensors
    for (int k = 0; k < 3; k++) tick(1'b1, 1'bx, 1'bx);
    check("reset_LA_const", la1, 2'b00);
    check("reset_LB_const", lb1, 2'b10);

    // Traffic on A keeps A green
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0);

    // A clears, B has traffic: handover to B, then hold
    tick(1'b0, 1'b0, 1'b1);
    check("y1_A_yellow", la1, 2'b01);
    tick(1'b0, 1'b0, 1'b1);
    check("y1_B_green", lb1, 2'b00);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 1'b1);

    // B clears, A has traffic: handover back to A, then hold
    tick(1'b0, 1'b1, 1'b0);
    check("y1_B_yellow", lb1, 2'b01);
    tick(1'b0, 1'b1, 1'b0);
    check("y1_A_green", la1, 2'b00);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, 1'b0);

    // Both sensors active: current green is kept (A)
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b1);

    // Move to B, then both active keeps B green
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b1);

    // No traffic anywhere: continuous cycling
    for (int k = 0; k < 16; k++) tick(1'b0, 1'b0, 1'b0);

    // Reset asserted during A yellow
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check("rst_in_S1_LA", la1, 2'b00);

    // Reset asserted during B yellow
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("rst_in_S3_LB", lb1, 2'b10);

    // Randomized traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
